// File: rtl/mvau_act_feeder.sv
// -----------------------------------------------------------------------------
// mvau_act_feeder
//
// Transmit side of the MVAU input-activation stream. Accepts one input vector
// (SF words of TI bits) from the upstream layer over valid/ready, buffers it,
// then replays it NF times back-to-back on a valid-only output, one word per
// cycle. mvau has no backpressure, so a replay always runs to completion.
//
// Configuration macro:
//   MVAU_FEEDER_DBUF_EN  defined   -> two ping-pong banks; the next vector loads
//                                     while the current one is replayed.
//                        undefined -> a single bank; upstream is held off from
//                                     the last accept until the replay ends.
//
// Parameters:
//   SIMD   activation elements per stream word
//   TSRCI  bits per activation element
//   SF     words per input vector (>= 1)
//   NF     replays per vector (>= 1)
//   TI     stream word width, TSRCI*SIMD (derived, not overridable)
//
// Ports:
//   clk      in   1   clock, all logic on posedge
//   rst      in   1   synchronous active-high reset
//   s_data   in   TI  upstream activation word
//   s_valid  in   1   s_data valid
//   s_ready  out  1   feeder can take s_data (word taken when s_valid && s_ready)
//   out      out  TI  activation word to mvau.in
//   out_v    out  1   out valid, to mvau.in_v
// -----------------------------------------------------------------------------
module mvau_act_feeder #(
  parameter  int SIMD  = 2,
  parameter  int TSRCI = 4,
  parameter  int SF    = 3,
  parameter  int NF    = 2,
  localparam int TI    = TSRCI * SIMD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TI-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [TI-1:0] out,
  output logic          out_v
);

  localparam int PW = (SF > 1) ? $clog2(SF) : 1;
  localparam int RW = (NF > 1) ? $clog2(NF) : 1;

`ifdef MVAU_FEEDER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  // Bank 1 is only ever written in the double-buffered build.
  logic [TI-1:0] mem_q [2][SF];
  logic          mem_we;

  state_e        state_q,   state_d;
  logic [1:0]    full_q,    full_d;
  logic          wb_q,      wb_d;
  logic          rb_q,      rb_d;
  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [TI-1:0] out_q,     out_d;
  logic          out_v_q,   out_v_d;
  logic          s_ready_q, s_ready_d;
  logic          accept;

  assign s_ready = s_ready_q;
  assign out     = out_q;
  assign out_v   = out_v_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    full_d    = full_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rep_cnt_d = rep_cnt_q;
    out_d     = out_q;
    out_v_d   = 1'b0;
    mem_we    = 1'b0;

    accept = s_valid && s_ready_q;

    // Write side: fill bank[wb] word by word; the last word seals the bank.
    if (accept) begin
      mem_we = 1'b1;
      if (wr_ptr_q == PW'(SF - 1)) begin
        wr_ptr_d     = '0;
        full_d[wb_q] = 1'b1;
        wb_d         = DBUF ? ~wb_q : 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // Read side: one word per cycle while replaying; the last word of the
    // last replay releases the bank and moves to the other one.
    if (state_q == REPLAY) begin
      out_d   = mem_q[rb_q][rd_ptr_q];
      out_v_d = 1'b1;
      if (rd_ptr_q == PW'(SF - 1)) begin
        rd_ptr_d = '0;
        if (rep_cnt_q == RW'(NF - 1)) begin
          rep_cnt_d    = '0;
          full_d[rb_q] = 1'b0;
          rb_d         = DBUF ? ~rb_q : 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    // Replay continues without a bubble whenever the next read bank is
    // already sealed, including one sealed on this very edge.
    state_d = full_d[rb_d] ? REPLAY : IDLE;

    // A bank freed on this edge is offered upstream only from the next edge
    // on (second term), so s_ready never rises in the same cycle as the free.
    s_ready_d = !full_d[wb_d] && !full_q[wb_d];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      full_q    <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rep_cnt_q <= '0;
      out_q     <= '0;
      out_v_q   <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rep_cnt_q <= rep_cnt_d;
      out_q     <= out_d;
      out_v_q   <= out_v_d;
      s_ready_q <= s_ready_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the full flags gate
  // every read, so stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wb_q][wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_mvau_act_feeder.sv
// -----------------------------------------------------------------------------
// tb_mvau_act_feeder
//
// Bench for mvau_act_feeder (SIMD=2, TSRCI=4, SF=3, NF=2) plus two corner
// instances (SF=1/NF=4 and SF=4/NF=1). A queue-level model of vectors waiting
// to be replayed predicts out, out_v and s_ready every cycle; directed tests
// add hand-computed literal expectations for ordering, latency and gaps.
// -----------------------------------------------------------------------------
module tb_mvau_act_feeder;

  localparam int SIMD  = 2;
  localparam int TSRCI = 4;
  localparam int SF    = 3;
  localparam int NF    = 2;
  localparam int TI    = TSRCI * SIMD;
`ifdef MVAU_FEEDER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TI-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [TI-1:0] out;
  logic          out_v;

  logic [7:0] c1_data = '0, c2_data = '0;
  logic       c1_valid = 1'b0, c2_valid = 1'b0;
  logic       c1_ready, c2_ready, c1_out_v, c2_out_v;
  logic [7:0] c1_out, c2_out;

  always #5 clk = ~clk;

  mvau_act_feeder #(.SIMD(SIMD), .TSRCI(TSRCI), .SF(SF), .NF(NF)) u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .out(out), .out_v(out_v)
  );

  mvau_act_feeder #(.SIMD(2), .TSRCI(4), .SF(1), .NF(4)) u_c1 (
    .clk(clk), .rst(rst), .s_data(c1_data), .s_valid(c1_valid),
    .s_ready(c1_ready), .out(c1_out), .out_v(c1_out_v)
  );

  mvau_act_feeder #(.SIMD(2), .TSRCI(4), .SF(4), .NF(1)) u_c2 (
    .clk(clk), .rst(rst), .s_data(c2_data), .s_valid(c2_valid),
    .s_ready(c2_ready), .out(c2_out), .out_v(c2_out_v)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: complete vectors queue up and are replayed in arrival order, each
  // SF*NF cycles long, starting the edge after completion at the earliest.
  // Upstream is ready when a bank is free, a bank freed on an edge being
  // counted as still held for that edge.
  // ---------------------------------------------------------------------------
  logic [SF*TI-1:0] vec_q[$];
  logic [TI-1:0]    fill_q[$];
  int               emit_idx = 0;
  logic             m_ready = 1'b0;
  logic             m_out_v = 1'b0;
  logic [TI-1:0]    m_out = '0;
  int               cyc = 0;
  logic [TI-1:0]    cap[$];
  int               cap_cyc[$];

  always begin
    logic [SF*TI-1:0] cur, nv;
    logic             acc;
    int               popped;
    @(posedge clk);
    cyc++;
    if (rst) begin
      vec_q.delete();
      fill_q.delete();
      emit_idx = 0;
      m_ready  = 1'b0;
      m_out_v  = 1'b0;
      m_out    = '0;
    end else begin
      acc    = s_valid && m_ready;
      popped = 0;
      if (vec_q.size() > 0) begin
        cur     = vec_q[0];
        m_out   = cur[(emit_idx % SF)*TI +: TI];
        m_out_v = 1'b1;
        emit_idx++;
        if (emit_idx == SF*NF) begin
          void'(vec_q.pop_front());
          emit_idx = 0;
          popped   = 1;
        end
      end else begin
        m_out_v = 1'b0;
      end
      if (acc) begin
        fill_q.push_back(s_data);
        if (fill_q.size() == SF) begin
          nv = '0;
          for (int i = 0; i < SF; i++) nv[i*TI +: TI] = fill_q[i];
          vec_q.push_back(nv);
          fill_q.delete();
        end
      end
      m_ready = (vec_q.size() + popped) < NB;
    end
    #1;
    check("out_v", out_v, m_out_v);
    check("out", out, m_out);
    check("s_ready", s_ready, m_ready);
    if (out_v) begin
      cap.push_back(out);
      cap_cyc.push_back(cyc);
    end
  end

  // Corner-instance capture.
  logic [7:0] c1_cap[$], c2_cap[$];
  int         c1_ready_hi = 0, c2_ready_hi = 0;

  always begin
    @(posedge clk);
    #1;
    if (c1_out_v) begin
      c1_cap.push_back(c1_out);
      if (c1_ready) c1_ready_hi++;
    end
    if (c2_out_v) begin
      c2_cap.push_back(c2_out);
      if (c2_ready) c2_ready_hi++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all are entered and left just after a negedge.
  // ---------------------------------------------------------------------------
  task automatic send_word(input logic [TI-1:0] d, output int acc_cyc);
    logic took;
    int   n;
    s_data  = d;
    s_valid = 1'b1;
    n       = 0;
    forever begin
      took = s_ready;
      @(negedge clk);
      if (took) break;
      n++;
      if (n > 100) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    acc_cyc = cyc;
    s_valid = 1'b0;
  endtask

  task automatic send_c(input int which, input logic [7:0] d);
    logic took;
    int   n;
    n = 0;
    if (which == 1) begin c1_data = d; c1_valid = 1'b1; end
    else            begin c2_data = d; c2_valid = 1'b1; end
    forever begin
      took = (which == 1) ? c1_ready : c2_ready;
      @(negedge clk);
      if (took) break;
      n++;
      if (n > 100) begin
        check("corner_accept_timeout", 1, 0);
        break;
      end
    end
    c1_valid = 1'b0;
    c2_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_cap();
    cap.delete();
    cap_cyc.delete();
  endtask

  // Expected stream: nvec vectors of consecutive bytes from base, each NF times.
  task automatic check_stream(input string name, input logic [7:0] base, input int nvec);
    check({name, "_len"}, cap.size(), nvec*SF*NF);
    for (int n = 0; n < cap.size() && n < nvec*SF*NF; n++)
      check(name, cap[n], base + 8'((n/(SF*NF))*SF + n%SF));
  endtask

  logic [7:0] exp_single [6] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
  logic [7:0] exp_fresh  [6] = '{8'h0A, 8'h0B, 8'h0C, 8'h0A, 8'h0B, 8'h0C};

  initial begin
    int k, n;
    int acc[9];

    // Reset values.
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_out_v", out_v, 0);
    check("rst_out", out, 0);
    check("rst_c1_ready", c1_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);

    // Single vector.
    clear_cap();
    send_word(8'h11, k);
    send_word(8'h22, k);
    send_word(8'h33, k);
    idle(12);
    check("single_len", cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++) check("single_word", cap[i], exp_single[i]);
    if (cap.size() == 6) begin
      check("single_latency", cap_cyc[0] - k, 1);
      check("single_contig", cap_cyc[5] - cap_cyc[0], 5);
    end
    check("single_idle_out_v", out_v, 0);

    // Upstream gaps: nothing may appear before the third word is accepted.
    clear_cap();
    send_word(8'h11, k);
    idle(2);
    send_word(8'h22, k);
    idle(1);
    check("gap_no_early_out", cap.size(), 0);
    send_word(8'h33, k);
    idle(12);
    check("gap_len", cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++) check("gap_word", cap[i], exp_single[i]);
    if (cap.size() > 0) check("gap_latency", cap_cyc[0] - k, 1);

    // Back-to-back vectors A=01..03, B=04..06.
    clear_cap();
    for (int i = 0; i < 6; i++) send_word(8'(8'h01 + i), acc[i]);
    idle(30);
    check_stream("b2b", 8'h01, 2);
    if (cap.size() == 12) begin
`ifdef MVAU_FEEDER_DBUF_EN
      check("b2b_contig", cap_cyc[11] - cap_cyc[0], 11);
`else
      check("b2b_gap", cap_cyc[6] - cap_cyc[5], SF + 2);
`endif
    end

    // Backpressure: three vectors offered with s_valid held high.
    clear_cap();
    for (int i = 0; i < 9; i++) send_word(8'(8'h21 + i), acc[i]);
    idle(30);
    check_stream("bp", 8'h21, 3);
    if (cap.size() == 18) begin
`ifdef MVAU_FEEDER_DBUF_EN
      check("bp_third_accept", acc[6] - cap_cyc[5], 2);
`else
      check("bp_second_accept", acc[3] - cap_cyc[5], 2);
      check("bp_third_accept", acc[6] - cap_cyc[11], 2);
`endif
    end

    // Reset on the 4th output cycle, then a fresh vector.
    clear_cap();
    send_word(8'h31, k);
    send_word(8'h32, k);
    send_word(8'h33, k);
    n = 0;
    while (cap.size() < 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_4th", cap.size(), 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_v", out_v, 0);
    check("midrst_s_ready", s_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    clear_cap();
    send_word(8'h0A, k);
    send_word(8'h0B, k);
    send_word(8'h0C, k);
    idle(12);
    check("fresh_len", cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++) check("fresh_word", cap[i], exp_fresh[i]);

    // Reset mid-fill discards the partial vector.
    send_word(8'h41, k);
    send_word(8'h42, k);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_cap();
    send_word(8'h51, k);
    send_word(8'h52, k);
    send_word(8'h53, k);
    idle(12);
    check_stream("midfill", 8'h51, 1);

    // Corner instances: SF=1/NF=4 and SF=4/NF=1.
    c1_cap.delete();
    c2_cap.delete();
    c1_ready_hi = 0;
    c2_ready_hi = 0;
    send_c(1, 8'h5A);
    idle(8);
    check("c1_len", c1_cap.size(), 4);
    for (int i = 0; i < c1_cap.size(); i++) check("c1_word", c1_cap[i], 8'h5A);
    send_c(2, 8'hA1);
    send_c(2, 8'hA2);
    send_c(2, 8'hA3);
    send_c(2, 8'hA4);
    idle(8);
    check("c2_len", c2_cap.size(), 4);
    for (int i = 0; i < c2_cap.size(); i++) check("c2_word", c2_cap[i], 8'(8'hA1 + i));
`ifndef MVAU_FEEDER_DBUF_EN
    check("c1_ready_low_in_replay", c1_ready_hi, 0);
    check("c2_ready_low_in_replay", c2_ready_hi, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d of %0d checks failed so far", fails, tests);
    $fatal(1, "watchdog expired");
  end

endmodule
